// File: rtl/apb_regfile_wait_if.sv
// APB4 completer-side bus bundle for apb_regfile_wait.
// Carries address/control/write data towards the slave and read data/handshake back.
interface apb_regfile_wait_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic [AW-1:0]   paddr;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [DW/8-1:0] pstrb;
    logic [DW-1:0]   pwdata;
    logic [DW-1:0]   prdata;
    logic            pready;
    logic            pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pstrb, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pstrb, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_regfile_wait.sv
// Parametrised APB4 register file: NREGS byte-strobed RW words, RO status words, error on illegal access.
// Latency: 1 setup + WAIT_CYCLES+1 access cycles; pready held low until the wait counter reaches WAIT_CYCLES.
module apb_regfile_wait #(
    parameter int               DW          = 32,
    parameter int               AW          = 8,
    parameter int               NREGS       = 8,
    parameter int               WAIT_CYCLES = 0,
    parameter logic [NREGS-1:0] RO_MASK     = '0
) (
    input  logic                pclk,
    input  logic                presetn,
    apb_regfile_wait_if.slave   apb,
    output logic [NREGS*DW-1:0] ctrl_out,
    input  logic [NREGS*DW-1:0] status_in,
    output logic [NREGS-1:0]    wr_pulse
);
    localparam int NB = DW / 8;
    localparam int IW = AW - 2;

    logic [DW-1:0] regs [NREGS];
    logic [3:0]    wcnt;
    logic [IW-1:0] idx;
    logic          access;
    logic          valid;
    logic          ro;
    logic          wr_hit;
    logic [DW-1:0] rd_word;
    logic          unused_ok;

    assign idx    = apb.paddr[AW-1:2];
    assign access = apb.psel & apb.penable;

    // Reset gating keeps pready low while presetn is asserted, even for zero-wait builds.
    assign apb.pready = presetn & access & (wcnt == 4'(WAIT_CYCLES));
    assign wr_hit     = apb.pready & apb.pwrite;

    always_comb begin
        valid   = 1'b0;
        ro      = 1'b0;
        rd_word = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (idx == IW'(i)) begin
                valid   = 1'b1;
                ro      = RO_MASK[i];
                rd_word = RO_MASK[i] ? status_in[i*DW +: DW] : regs[i];
            end
        end
    end

    assign apb.pslverr = apb.pready & (~valid | (apb.pwrite & ro));
    assign apb.prdata  = (apb.pready & ~apb.pwrite & valid) ? rd_word : '0;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wcnt     <= '0;
            wr_pulse <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (!access) begin
                wcnt <= '0;
            end else if (!apb.pready) begin
                wcnt <= wcnt + 4'd1;
            end
            // RO slots are excluded here, so their storage stays at its reset value.
            for (int i = 0; i < NREGS; i++) begin
                wr_pulse[i] <= wr_hit && (idx == IW'(i)) && !RO_MASK[i];
                if (wr_hit && (idx == IW'(i)) && !RO_MASK[i]) begin
                    for (int b = 0; b < NB; b++) begin
                        if (apb.pstrb[b]) begin
                            regs[i][b*8 +: 8] <= apb.pwdata[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        ctrl_out = '0;
        for (int i = 0; i < NREGS; i++) begin
            ctrl_out[i*DW +: DW] = RO_MASK[i] ? '0 : regs[i];
        end
    end

    assign unused_ok = ^{apb.paddr[1:0], status_in};
endmodule

// File: tb/tb_apb_regfile_wait.sv
// Directed bench: zero-wait RO-mapped instance (dut0) and 3-wait-state instance (dut3) on shared clock/reset.
module tb_apb_regfile_wait;
    logic         pclk;
    logic         presetn_v;
    logic         tgt;
    logic         psel_v, penable_v, pwrite_v;
    logic [7:0]   paddr_v;
    logic [3:0]   pstrb_v;
    logic [31:0]  pwdata_v;
    logic [255:0] ctrl0, ctrl3, status0, status3;
    logic [7:0]   wr_pulse0, wr_pulse3;
    logic         pready_m, pslverr_m;
    logic [31:0]  prdata_m;
    logic [31:0]  rd_o;
    logic         err_o, st_o;
    int           acc_o;
    logic [255:0] snap_c;
    int           checks;
    int           errors;

    apb_regfile_wait_if #(.AW(8), .DW(32)) if0 ();
    apb_regfile_wait_if #(.AW(8), .DW(32)) if3 ();

    assign if0.paddr   = paddr_v;
    assign if0.psel    = psel_v & ~tgt;
    assign if0.penable = penable_v;
    assign if0.pwrite  = pwrite_v;
    assign if0.pstrb   = pstrb_v;
    assign if0.pwdata  = pwdata_v;
    assign if3.paddr   = paddr_v;
    assign if3.psel    = psel_v & tgt;
    assign if3.penable = penable_v;
    assign if3.pwrite  = pwrite_v;
    assign if3.pstrb   = pstrb_v;
    assign if3.pwdata  = pwdata_v;

    assign pready_m  = tgt ? if3.pready  : if0.pready;
    assign pslverr_m = tgt ? if3.pslverr : if0.pslverr;
    assign prdata_m  = tgt ? if3.prdata  : if0.prdata;

    assign status0 = {{7{32'h5A5A_0F0F}}, 32'h0000_CAFE};
    assign status3 = {8{32'hEEEE_1111}};

    apb_regfile_wait #(.DW(32), .AW(8), .NREGS(8), .WAIT_CYCLES(0), .RO_MASK(8'h01)) dut0 (
        .pclk(pclk), .presetn(presetn_v), .apb(if0.slave),
        .ctrl_out(ctrl0), .status_in(status0), .wr_pulse(wr_pulse0)
    );

    apb_regfile_wait #(.DW(32), .AW(8), .NREGS(8), .WAIT_CYCLES(3), .RO_MASK(8'h00)) dut3 (
        .pclk(pclk), .presetn(presetn_v), .apb(if3.slave),
        .ctrl_out(ctrl3), .status_in(status3), .wr_pulse(wr_pulse3)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one transfer; returns at the completing (or aborting) access cycle with psel still driven.
    task automatic xfer(input logic t, input logic [7:0] a, input logic w, input logic [3:0] s,
                        input logic [31:0] d, input int abort_at, input logic by_reset);
        logic         done;
        logic [255:0] snap;
        @(negedge pclk);
        tgt = t; psel_v = 1'b1; penable_v = 1'b0;
        paddr_v = a; pwrite_v = w; pstrb_v = s; pwdata_v = d;
        acc_o = 0; rd_o = '0; err_o = 1'b0; st_o = 1'b1; done = 1'b0;
        snap = t ? ctrl3 : ctrl0;
        @(negedge pclk);
        penable_v = 1'b1;
        while (!done && acc_o < 40) begin
            #1;
            acc_o++;
            if (pready_m) begin
                rd_o = prdata_m; err_o = pslverr_m; done = 1'b1;
            end else begin
                if ((t ? ctrl3 : ctrl0) !== snap) st_o = 1'b0;
                if (acc_o == abort_at) begin
                    if (by_reset) presetn_v = 1'b0;
                    else begin psel_v = 1'b0; penable_v = 1'b0; end
                    done = 1'b1;
                end else begin
                    @(negedge pclk);
                end
            end
        end
        if (!done) chk("pready_timeout", {255'd0, pready_m}, 256'd1);
    endtask

    task automatic apb_wr(input logic t, input logic [7:0] a, input logic [3:0] s, input logic [31:0] d);
        xfer(t, a, 1'b1, s, d, 0, 1'b0);
    endtask

    task automatic apb_rd(input logic t, input logic [7:0] a);
        xfer(t, a, 1'b0, 4'hF, 32'h0, 0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge pclk);
            psel_v = 1'b0; penable_v = 1'b0;
            #1;
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        presetn_v = 1'b0; tgt = 1'b0;
        psel_v = 1'b1; penable_v = 1'b1; pwrite_v = 1'b0;
        paddr_v = 8'h04; pstrb_v = 4'h0; pwdata_v = 32'h0;
        repeat (3) @(negedge pclk);
        #1;
        chk("rst_pready", {255'd0, if0.pready}, 256'd0);
        chk("rst_prdata", {224'd0, if0.prdata}, 256'd0);
        chk("rst_pslverr", {255'd0, if0.pslverr}, 256'd0);
        chk("rst_ctrl0", ctrl0, 256'd0);
        chk("rst_ctrl3", ctrl3, 256'd0);
        chk("rst_pulse0", {248'd0, wr_pulse0}, 256'd0);
        @(negedge pclk);
        psel_v = 1'b0; penable_v = 1'b0; presetn_v = 1'b1;

        // Zero-wait write/read
        apb_wr(0, 8'h04, 4'hF, 32'hDEAD_BEEF);
        chk("zw_wr_acc", acc_o, 1);
        chk("zw_wr_err", {255'd0, err_o}, 256'd0);
        idle(1);
        chk("zw_word1", {224'd0, ctrl0[32 +: 32]}, {224'd0, 32'hDEAD_BEEF});
        chk("zw_pulse", {248'd0, wr_pulse0}, {248'd0, 8'h02});
        idle(1);
        chk("zw_pulse_end", {248'd0, wr_pulse0}, 256'd0);
        apb_rd(0, 8'h04);
        chk("zw_rd_dat", {224'd0, rd_o}, {224'd0, 32'hDEAD_BEEF});
        chk("zw_rd_err", {255'd0, err_o}, 256'd0);
        chk("zw_rd_acc", acc_o, 1);

        // Byte strobes, back-to-back
        apb_wr(0, 8'h08, 4'hF, 32'h1122_3344);
        apb_wr(0, 8'h08, 4'h5, 32'hAABB_CCDD);
        apb_rd(0, 8'h08);
        chk("strb_rd", {224'd0, rd_o}, {224'd0, 32'h11BB_33DD});
        apb_wr(0, 8'h08, 4'h0, 32'hFFFF_FFFF);
        idle(1);
        chk("strb0_pulse", {248'd0, wr_pulse0}, {248'd0, 8'h04});
        chk("strb0_word2", {224'd0, ctrl0[64 +: 32]}, {224'd0, 32'h11BB_33DD});

        // Illegal index
        snap_c = ctrl0;
        apb_wr(0, 8'h20, 4'hF, 32'hFFFF_FFFF);
        chk("badwr_err", {255'd0, err_o}, 256'd1);
        idle(1);
        chk("badwr_ctrl", ctrl0, snap_c);
        chk("badwr_pulse", {248'd0, wr_pulse0}, 256'd0);
        apb_rd(0, 8'h3C);
        chk("badrd_dat", {224'd0, rd_o}, 256'd0);
        chk("badrd_err", {255'd0, err_o}, 256'd1);

        // Read-only status register 0
        apb_rd(0, 8'h00);
        chk("ro_rd", {224'd0, rd_o}, {224'd0, 32'h0000_CAFE});
        chk("ro_rd_err", {255'd0, err_o}, 256'd0);
        apb_wr(0, 8'h00, 4'hF, 32'h1234_5678);
        chk("ro_wr_err", {255'd0, err_o}, 256'd1);
        idle(1);
        chk("ro_wr_pulse", {248'd0, wr_pulse0}, 256'd0);
        chk("ro_ctrl0", {224'd0, ctrl0[0 +: 32]}, 256'd0);
        apb_rd(0, 8'h00);
        chk("ro_rd2", {224'd0, rd_o}, {224'd0, 32'h0000_CAFE});

        // Low address bits ignored; last valid index
        apb_rd(0, 8'h07);
        chk("unalign_rd", {224'd0, rd_o}, {224'd0, 32'hDEAD_BEEF});
        apb_wr(0, 8'h1C, 4'hF, 32'h0BAD_F00D);
        apb_rd(0, 8'h1C);
        chk("last_rd", {224'd0, rd_o}, {224'd0, 32'h0BAD_F00D});
        chk("last_err", {255'd0, err_o}, 256'd0);
        idle(1);

        // Three wait states
        apb_wr(1, 8'h0C, 4'hF, 32'hCAFE_F00D);
        chk("ws_wr_acc", acc_o, 4);
        chk("ws_stable", {255'd0, st_o}, 256'd1);
        chk("ws_wr_err", {255'd0, err_o}, 256'd0);
        idle(1);
        chk("ws_word3", {224'd0, ctrl3[96 +: 32]}, {224'd0, 32'hCAFE_F00D});
        chk("ws_pulse", {248'd0, wr_pulse3}, {248'd0, 8'h08});

        // Abort in wait cycle 2
        xfer(1, 8'h10, 1'b1, 4'hF, 32'h5555_5555, 2, 1'b0);
        chk("abort_acc", acc_o, 2);
        idle(1);
        chk("abort_pulse", {248'd0, wr_pulse3}, 256'd0);
        chk("abort_word4", {224'd0, ctrl3[128 +: 32]}, 256'd0);
        apb_wr(1, 8'h10, 4'hF, 32'h0F0F_0F0F);
        chk("restart_acc", acc_o, 4);
        idle(1);
        chk("restart_word4", {224'd0, ctrl3[128 +: 32]}, {224'd0, 32'h0F0F_0F0F});
        chk("restart_pulse", {248'd0, wr_pulse3}, {248'd0, 8'h10});

        // Back-to-back reads with waits, then an error read with waits
        apb_rd(1, 8'h0C);
        chk("b2b_rd1", {224'd0, rd_o}, {224'd0, 32'hCAFE_F00D});
        apb_rd(1, 8'h10);
        chk("b2b_acc2", acc_o, 4);
        chk("b2b_rd2", {224'd0, rd_o}, {224'd0, 32'h0F0F_0F0F});
        apb_rd(1, 8'h3C);
        chk("ws_bad_acc", acc_o, 4);
        chk("ws_bad_err", {255'd0, err_o}, 256'd1);
        chk("ws_bad_dat", {224'd0, rd_o}, 256'd0);
        idle(1);

        // Reset during a wait cycle
        xfer(1, 8'h14, 1'b1, 4'hF, 32'hFFFF_FFFF, 2, 1'b1);
        #1;
        chk("mrst_pready", {255'd0, pready_m}, 256'd0);
        chk("mrst_ctrl3", ctrl3, 256'd0);
        chk("mrst_ctrl0", ctrl0, 256'd0);
        @(negedge pclk);
        psel_v = 1'b0; penable_v = 1'b0; presetn_v = 1'b1;
        apb_wr(1, 8'h14, 4'hF, 32'h0102_0304);
        chk("post_acc", acc_o, 4);
        chk("post_err", {255'd0, err_o}, 256'd0);
        idle(1);
        chk("post_word5", {224'd0, ctrl3[160 +: 32]}, {224'd0, 32'h0102_0304});
        chk("post_pulse", {248'd0, wr_pulse3}, {248'd0, 8'h20});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
